// File: rtl/carry_seq.sv
// Bit-serial adder sequencer: walks operands LSB-first through an external
// full-adder cell, one bit per clock, and collects sum, carry-out and overflow.
module carry_seq #(
  parameter int   WIDTH   = 8,
  parameter logic CI_INIT = 1'b0
) (
  input  logic             QCK,
  input  logic             QRTN,
  input  logic             START,
  input  logic [WIDTH-1:0] A_IN,
  input  logic [WIDTH-1:0] B_IN,
  output logic             LI_A,
  output logic             LI_B,
  output logic             CI_OUT,
  input  logic             FZ,
  input  logic             CO,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF
);
  localparam int            IW       = $clog2(WIDTH);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nx;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_q, b_q;
  logic             accept, last, run;

  assign run  = (state == S_RUN);
  assign last = (idx == IDX_LAST);

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      S_IDLE: if (START) begin accept = 1'b1; state_nx = S_RUN; end
      S_RUN:  if (last) state_nx = S_DONE;
      S_DONE: begin
        // back-to-back: a new op can be taken in the result cycle itself
        if (START) begin accept = 1'b1; state_nx = S_RUN; end
        else state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge QCK or negedge QRTN) begin
    if (!QRTN) begin
      state <= S_IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      SUM   <= '0;
      COUT  <= 1'b0;
      OVF   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_q   <= A_IN;
        b_q   <= B_IN;
        idx   <= '0;
        carry <= CI_INIT;
      end else if (run) begin
        SUM[idx] <= FZ;
        carry    <= CO;
        // idx parks at the MSB; signed overflow is carry-in XOR carry-out of the MSB
        if (last) begin
          COUT <= CO;
          OVF  <= CO ^ carry;
        end else begin
          idx <= idx + IW'(1);
        end
      end
    end
  end

  assign BUSY   = run;
  assign DONE   = (state == S_DONE);
  assign LI_A   = run & a_q[idx];
  assign LI_B   = run & b_q[idx];
  assign CI_OUT = run & carry;
endmodule

// File: tb/tb_carry_seq.sv
// Directed bench for carry_seq: two instances (CI_INIT 0 and 1) share stimulus,
// each closed through its own behavioural full-adder cell.
module tb_carry_seq;
  logic       QCK = 1'b0;
  logic       QRTN, START;
  logic [7:0] A_IN, B_IN;
  logic       li_a0, li_b0, ci0, fz0, co0, busy0, done0, cout0, ovf0;
  logic       li_a1, li_b1, ci1, fz1, co1, busy1, done1, cout1, ovf1;
  logic [7:0] sum0, sum1;
  int         total = 0;
  int         bad   = 0;

  always #5 QCK = ~QCK;

  assign fz0 = li_a0 ^ li_b0 ^ ci0;
  assign co0 = (li_a0 & li_b0) | (ci0 & (li_a0 ^ li_b0));
  assign fz1 = li_a1 ^ li_b1 ^ ci1;
  assign co1 = (li_a1 & li_b1) | (ci1 & (li_a1 ^ li_b1));

  carry_seq #(.WIDTH(8), .CI_INIT(1'b0)) dut0 (
    .QCK(QCK), .QRTN(QRTN), .START(START), .A_IN(A_IN), .B_IN(B_IN),
    .LI_A(li_a0), .LI_B(li_b0), .CI_OUT(ci0), .FZ(fz0), .CO(co0),
    .BUSY(busy0), .DONE(done0), .SUM(sum0), .COUT(cout0), .OVF(ovf0));

  carry_seq #(.WIDTH(8), .CI_INIT(1'b1)) dut1 (
    .QCK(QCK), .QRTN(QRTN), .START(START), .A_IN(A_IN), .B_IN(B_IN),
    .LI_A(li_a1), .LI_B(li_b1), .CI_OUT(ci1), .FZ(fz1), .CO(co1),
    .BUSY(busy1), .DONE(done1), .SUM(sum1), .COUT(cout1), .OVF(ovf1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge QCK);
    #1;
  endtask

  function automatic logic ovf_of(input logic [7:0] a, input logic [7:0] b, input logic [7:0] s);
    return (a[7] == b[7]) && (s[7] != a[7]);
  endfunction

  // One operation: accept, scramble inputs during RUN, check per-bit cell drive,
  // latency, results of both instances, then the single-cycle DONE pulse.
  task automatic op(input logic [7:0] a, input logic [7:0] b, input string tag,
                    output logic [7:0] ci_seq);
    logic [8:0] e0, e1;
    int c, nb;
    e0 = {1'b0, a} + {1'b0, b};
    e1 = {1'b0, a} + {1'b0, b} + 9'd1;
    A_IN = a; B_IN = b; START = 1'b1;
    tick();
    START = 1'b0; A_IN = ~a; B_IN = ~b;
    c = 1; nb = 0; ci_seq = '0;
    while (!done0 && c < 30) begin
      chk({tag, ":busy"}, busy0, 1);
      chk({tag, ":li_a"}, li_a0, a[nb[2:0]]);
      chk({tag, ":li_b"}, li_b0, b[nb[2:0]]);
      ci_seq[nb[2:0]] = ci0;
      nb++;
      tick();
      c++;
    end
    chk({tag, ":latency"}, c, 9);
    chk({tag, ":busy_cycles"}, nb, 8);
    chk({tag, ":done1"}, done1, 1);
    chk({tag, ":sum0"}, sum0, e0[7:0]);
    chk({tag, ":cout0"}, cout0, e0[8]);
    chk({tag, ":ovf0"}, ovf0, ovf_of(a, b, e0[7:0]));
    chk({tag, ":sum1"}, sum1, e1[7:0]);
    chk({tag, ":cout1"}, cout1, e1[8]);
    chk({tag, ":ovf1"}, ovf1, ovf_of(a, b, e1[7:0]));
    tick();
    chk({tag, ":done_pulse"}, {done0, done1, busy0}, 0);
    chk({tag, ":idle_drive"}, {li_a0, li_b0, ci0, li_a1, li_b1, ci1}, 0);
    chk({tag, ":sum_hold"}, sum0, e0[7:0]);
  endtask

  initial begin
    logic [7:0] cs;
    int c, d1, d2, nd;
    QRTN = 1'b0; START = 1'b0; A_IN = 8'h00; B_IN = 8'h00;
    #2;
    chk("rst:sum", {sum0, sum1}, 0);
    chk("rst:flags", {cout0, ovf0, busy0, done0, cout1, ovf1, busy1, done1}, 0);
    chk("rst:drive", {li_a0, li_b0, ci0, li_a1, li_b1, ci1}, 0);
    tick();
    QRTN = 1'b1;

    // first edge after reset release accepts
    op(8'h5A, 8'h3C, "op5a3c", cs);
    chk("op5a3c:sum", sum0, 8'h96);
    chk("op5a3c:cout_ovf", {cout0, ovf0}, 2'b01);

    op(8'hFF, 8'h01, "opff01", cs);
    chk("opff01:ci_seq", cs, 8'hFE);
    chk("opff01:sum", sum0, 8'h00);
    chk("opff01:cout_ovf", {cout0, ovf0}, 2'b10);

    op(8'h00, 8'h00, "op0000", cs);
    chk("ciinit:sum", sum1, 8'h01);
    chk("ciinit:cout_ovf", {cout1, ovf1}, 2'b00);

    // START held high, operands churning every cycle
    START = 1'b1; A_IN = 8'h11; B_IN = 8'h22;
    tick();
    c = 1; d1 = 0; d2 = 0;
    while (d2 == 0 && c < 60) begin
      if (done0) begin
        if (d1 == 0) begin
          d1 = c;
          chk("b2b:sum_a", sum0, 8'h33);
          A_IN = 8'h40; B_IN = 8'h40;
        end else begin
          d2 = c;
          chk("b2b:sum_b", sum0, 8'h80);
          chk("b2b:cout_ovf_b", {cout0, ovf0}, 2'b01);
          chk("b2b:sum_b1", sum1, 8'h81);
        end
      end else begin
        A_IN = 8'($urandom); B_IN = 8'($urandom);
      end
      if (d2 == 0) begin
        tick();
        c++;
      end
    end
    START = 1'b0;
    chk("b2b:done_a", d1, 9);
    chk("b2b:done_b", d2, 18);

    // reset in RUN cycle 4
    A_IN = 8'h12; B_IN = 8'h34; START = 1'b1;
    tick();
    START = 1'b0;
    tick(); tick(); tick();
    chk("midrst:busy_before", busy0, 1);
    QRTN = 1'b0;
    #1;
    chk("midrst:sum", {sum0, sum1}, 0);
    chk("midrst:flags", {cout0, ovf0, busy0, done0, cout1, ovf1, busy1, done1}, 0);
    chk("midrst:drive", {li_a0, li_b0, ci0, li_a1, li_b1, ci1}, 0);
    tick(); tick();
    QRTN = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done0 || done1 || busy0) nd++;
      tick();
    end
    chk("midrst:no_done", nd, 0);
    op(8'h12, 8'h34, "postrst", cs);
    chk("postrst:sum", sum0, 8'h46);

    for (int i = 0; i < 1000; i++)
      op(8'($urandom), 8'($urandom), "rnd", cs);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
